// File: rtl/wb_cfg_pkg.sv
// ---------------------------------------------------------------------------
// wb_cfg_pkg
//   Shared definitions for the Wishbone configuration loader:
//   register offsets, CTRL bit indices, STATUS field positions, the shifter
//   FSM state type and a helper that assembles the STATUS word.
// ---------------------------------------------------------------------------
package wb_cfg_pkg;

  // Register offsets within the 256-byte slave window
  localparam logic [7:0] CTRL_OFF   = 8'h00;
  localparam logic [7:0] STATUS_OFF = 8'h04;
  localparam logic [7:0] DATA_OFF   = 8'h08;

  // CTRL register bits
  localparam int CTRL_CLR_BIT = 0;
  localparam int CTRL_SET_BIT = 1;

  // STATUS register fields
  localparam int STAT_SHIFTING_BIT  = 0;
  localparam int STAT_HOLD_FULL_BIT = 1;
  localparam int STAT_CFG_SET_BIT   = 2;
  localparam int STAT_ERR_BIT       = 3;
  localparam int STAT_WCNT_LSB      = 16;
  localparam int STAT_WCNT_W        = 16;

  // Configuration word width and bit counter terminal value
  localparam int          CFG_WORD_W   = 32;
  localparam logic [4:0]  BIT_CNT_LAST = 5'd31;

  // Shifter FSM states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_e;

  // Assemble the STATUS read value from its individual fields
  function automatic logic [31:0] pack_status(
    input logic                   shifting,
    input logic                   hold_full,
    input logic                   cfg_set,
    input logic                   err,
    input logic [STAT_WCNT_W-1:0] word_cnt
  );
    logic [31:0] s;
    s                                           = '0;
    s[STAT_SHIFTING_BIT]                        = shifting;
    s[STAT_HOLD_FULL_BIT]                       = hold_full;
    s[STAT_CFG_SET_BIT]                         = cfg_set;
    s[STAT_ERR_BIT]                             = err;
    s[STAT_WCNT_LSB +: STAT_WCNT_W]             = word_cnt;
    return s;
  endfunction

endpackage

// File: rtl/wb_cfg_if.sv
// ---------------------------------------------------------------------------
// wb_cfg_if
//   Wishbone slave-side bus bundle used between the management SoC and the
//   configuration loader.
//   master modport : drives stb/cyc/we/sel/data/addr, receives ack/data_o
//   slave  modport : receives the request, drives ack/data_o
// ---------------------------------------------------------------------------
interface wb_cfg_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_data_i;
  logic [31:0] wbs_addr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_data_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_data_i, wbs_addr_i,
    input  wbs_ack_o, wbs_data_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_data_i, wbs_addr_i,
    output wbs_ack_o, wbs_data_o
  );
endinterface

// File: rtl/wb_cfg_loader_shifter.sv
// ---------------------------------------------------------------------------
// cfg_shifter
//   Holding register plus serialiser for the fabric configuration chain.
//   A word offered on load_valid_i (only while load_ready_o) is parked in the
//   holding register, then shifted out LSB-first, one bit per clock. A word
//   waiting in the holding register is picked up on the last bit of the
//   current word so consecutive words stream without a gap.
//
//   clk, rst_n      : clock, asynchronous active-low reset
//   load_valid_i    : load the holding register this cycle
//   load_data_i     : 32-bit configuration word
//   load_ready_o    : holding register empty
//   clear_i         : abort shifting, empty hold, zero the word counter
//   cfg_shift_en_o  : registered, chain advances this cycle
//   cfg_bit_o       : registered serial bit
//   shifting_o      : FSM in SHIFT
//   hold_full_o     : holding register occupied
//   word_cnt_o      : saturating count of fully shifted words
// ---------------------------------------------------------------------------
module cfg_shifter
  import wb_cfg_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid_i,
  input  logic [CFG_WORD_W-1:0] load_data_i,
  output logic                  load_ready_o,
  input  logic                  clear_i,
  output logic                  cfg_shift_en_o,
  output logic                  cfg_bit_o,
  output logic                  shifting_o,
  output logic                  hold_full_o,
  output logic [CNT_W-1:0]      word_cnt_o
);

  localparam logic [CNT_W-1:0] WORD_CNT_MAX = {CNT_W{1'b1}};

  shift_state_e          state_q, state_d;
  logic [CFG_WORD_W-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [CFG_WORD_W-1:0] sreg_q, sreg_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
  logic                  shift_en_q, shift_en_d;
  logic                  cfg_bit_q, cfg_bit_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sreg_q      <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      shift_en_q  <= 1'b0;
      cfg_bit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sreg_q      <= sreg_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      shift_en_q  <= shift_en_d;
      cfg_bit_q   <= cfg_bit_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sreg_d      = sreg_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    shift_en_d  = 1'b0;
    cfg_bit_d   = 1'b0;

    // Loads are only offered while hold is empty, so they never collide
    // with the hold-to-sreg transfers below.
    if (load_valid_i) begin
      hold_d      = load_data_i;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          sreg_d      = hold_q;
          hold_full_d = 1'b0;
          bit_cnt_d   = '0;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en_d = 1'b1;
        cfg_bit_d  = sreg_q[0];
        sreg_d     = sreg_q >> 1;
        bit_cnt_d  = bit_cnt_q + 5'd1;
        if (bit_cnt_q == BIT_CNT_LAST) begin
          if (word_cnt_q != WORD_CNT_MAX) begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
          // Reload straight from hold so back-to-back words have no bubble
          if (hold_full_q) begin
            sreg_d      = hold_q;
            hold_full_d = 1'b0;
            bit_cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear overrides everything, including a reload happening this cycle
    if (clear_i) begin
      state_d     = ST_IDLE;
      hold_full_d = 1'b0;
      sreg_d      = '0;
      bit_cnt_d   = '0;
      word_cnt_d  = '0;
      shift_en_d  = 1'b0;
      cfg_bit_d   = 1'b0;
    end
  end

  assign load_ready_o   = ~hold_full_q;
  assign cfg_shift_en_o = shift_en_q;
  assign cfg_bit_o      = cfg_bit_q;
  assign shifting_o     = (state_q == ST_SHIFT);
  assign hold_full_o    = hold_full_q;
  assign word_cnt_o     = word_cnt_q;

endmodule

// File: rtl/wb_cfg_loader.sv
// ---------------------------------------------------------------------------
// wb_cfg_loader
//   Wishbone slave that accepts 32-bit configuration words and streams them
//   LSB-first into the fabric configuration chain through cfg_shifter.
//   Registers: CTRL (CLR/SET, write-only), STATUS (read-only), DATA
//   (write-only). cfg_set_o tells the fabric configuration is complete.
//
//   wb_clk_i, wb_rst_ni : clock, asynchronous active-low reset
//   wb                  : Wishbone slave bundle (stb/cyc/we/sel/data/addr,
//                         registered single-cycle ack and read data)
//   cfg_shift_en_o      : config chain advances this cycle
//   cfg_bit_o           : serial config bit
//   cfg_set_o           : configuration complete (level)
//   busy_o              : shifter active or holding register full
// ---------------------------------------------------------------------------
module wb_cfg_loader
  import wb_cfg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic     wb_clk_i,
  input  logic     wb_rst_ni,
  wb_cfg_if.slave  wb,
  output logic     cfg_shift_en_o,
  output logic     cfg_bit_o,
  output logic     cfg_set_o,
  output logic     busy_o
);

  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        cfg_set_q, cfg_set_d;
  logic        err_q, err_d;

  logic             load_valid;
  logic             load_ready;
  logic             shifter_clear;
  logic             shifting;
  logic             hold_full;
  logic [CNT_W-1:0] word_cnt;
  logic [15:0]      word_cnt_ext;

  logic       addr_hit;
  logic [7:0] offset;
  logic       request;
  logic       data_wr;
  logic       ctrl_wr;
  logic       ctrl_clr;
  logic       ctrl_set;
  logic       stall;
  logic       accept;

  cfg_shifter #(.CNT_W(CNT_W)) u_shifter (
    .clk            (wb_clk_i),
    .rst_n          (wb_rst_ni),
    .load_valid_i   (load_valid),
    .load_data_i    (wb.wbs_data_i),
    .load_ready_o   (load_ready),
    .clear_i        (shifter_clear),
    .cfg_shift_en_o (cfg_shift_en_o),
    .cfg_bit_o      (cfg_bit_o),
    .shifting_o     (shifting),
    .hold_full_o    (hold_full),
    .word_cnt_o     (word_cnt)
  );

  assign word_cnt_ext = 16'(word_cnt);

  // Request decode. Gating on ack_q keeps ack from firing two cycles in a
  // row while the master still holds stb after the first ack.
  assign addr_hit = (wb.wbs_addr_i[31:8] == BASE_ADDR[31:8]);
  assign offset   = wb.wbs_addr_i[7:0];
  assign request  = wb.wbs_stb_i & wb.wbs_cyc_i & addr_hit & ~ack_q;
  assign data_wr  = wb.wbs_we_i & (offset == DATA_OFF);
  assign ctrl_wr  = wb.wbs_we_i & (offset == CTRL_OFF);
  assign ctrl_clr = wb.wbs_data_i[CTRL_CLR_BIT];
  assign ctrl_set = wb.wbs_data_i[CTRL_SET_BIT];

  // DATA writes wait for an empty hold register; SET (without CLR) waits
  // until the shifter has fully drained so cfg_set_o never precedes the
  // last configuration bit.
  assign stall  = (data_wr & ~load_ready) |
                  (ctrl_wr & ~ctrl_clr & ctrl_set & (shifting | hold_full));
  assign accept = request & ~stall;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      cfg_set_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      cfg_set_q <= cfg_set_d;
      err_q     <= err_d;
    end
  end

  // Register access side effects all take effect on the ack edge
  always_comb begin
    ack_d         = 1'b0;
    rdata_d       = '0;
    cfg_set_d     = cfg_set_q;
    err_d         = err_q;
    load_valid    = 1'b0;
    shifter_clear = 1'b0;

    if (accept) begin
      ack_d = 1'b1;
      if (wb.wbs_we_i) begin
        if (offset == DATA_OFF) begin
          // Partial-lane writes and writes after SET are dropped and flagged
          if ((wb.wbs_sel_i == 4'hF) && !cfg_set_q) begin
            load_valid = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (offset == CTRL_OFF) begin
          if (ctrl_clr) begin
            shifter_clear = 1'b1;
            err_d         = 1'b0;
            cfg_set_d     = 1'b0;
          end else if (ctrl_set) begin
            cfg_set_d = 1'b1;
          end
        end
      end else if (offset == STATUS_OFF) begin
        rdata_d = pack_status(shifting, hold_full, cfg_set_q, err_q, word_cnt_ext);
      end
    end
  end

  assign wb.wbs_ack_o  = ack_q;
  assign wb.wbs_data_o = rdata_q;
  assign cfg_set_o     = cfg_set_q;
  assign busy_o        = shifting | hold_full;

endmodule
